// File: rtl/icache_resp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : icache_resp_buffer
// Description : In-order response FIFO between the icache data array and fetch,
//               with read-credit return, flush draining and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_resp_buffer #(
    parameter int DATA_W  = 256,
    parameter int TXNID_W = 4,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_issue,
    output logic               rd_allow,
    input  logic               in_vld,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [TXNID_W-1:0] in_txnid,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [DATA_W-1:0]  out_data,
    output logic [TXNID_W-1:0] out_txnid,
    input  logic               flush,
    output logic [CNT_W-1:0]   occupancy,
    output logic               err_ovf,
    output logic               err_unexp
);

    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]     ONE_X   = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]     DEPTH_X = (CNT_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  mem_data_q [DEPTH];
    logic [TXNID_W-1:0] mem_id_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unexp_q, err_unexp_d;

    logic             full;
    logic             do_pop;
    logic             push_req;
    logic             do_push;
    logic [CNT_W:0]   infl_sum;
    logic [CNT_W:0]   infl_net;
    logic [CNT_W:0]   credit_sum;

    always_comb begin
        full     = (count_q == DEPTH_C);
        do_pop   = (count_q != '0) && out_rdy;
        push_req = in_vld && !flush && (drop_cnt_q == '0);
        // A full buffer still takes the beat when the head leaves this cycle.
        do_push  = push_req && (!full || do_pop);

        infl_sum   = {1'b0, inflight_q} + (CNT_W + 1)'(rd_issue);
        infl_net   = (in_vld && (infl_sum != '0)) ? (infl_sum - ONE_X) : infl_sum;
        inflight_d = infl_net[CNT_W] ? CNT_MAX : infl_net[CNT_W-1:0];

        wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        drop_cnt_d = drop_cnt_q;
        if (in_vld && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end

        // Every read still outstanding after the flush cycle must be discarded.
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = inflight_d;
        end

        err_ovf_d   = err_ovf_q   | (push_req && full && !do_pop);
        err_unexp_d = err_unexp_q | (in_vld && (inflight_q == '0) && !rd_issue);

        credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
            drop_cnt_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            drop_cnt_q  <= drop_cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    // Storage carries no reset; contents are only observed while out_vld is high.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_id_q[wr_ptr_q]   <= in_txnid;
        end
    end

    assign rd_allow  = (credit_sum < DEPTH_X);
    assign out_vld   = (count_q != '0);
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_txnid = mem_id_q[rd_ptr_q];
    assign occupancy = count_q;
    assign err_ovf   = err_ovf_q;
    assign err_unexp = err_unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_resp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_resp_buffer
// Description : Directed and random bench for icache_resp_buffer against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_resp_buffer;

    localparam int DATA_W  = 256;
    localparam int TXNID_W = 4;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TXNID_W-1:0] id;
        logic [DATA_W-1:0]  d;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               rd_issue;
    logic               rd_allow;
    logic               in_vld;
    logic [DATA_W-1:0]  in_data;
    logic [TXNID_W-1:0] in_txnid;
    logic               out_vld;
    logic               out_rdy;
    logic [DATA_W-1:0]  out_data;
    logic [TXNID_W-1:0] out_txnid;
    logic               flush;
    logic [CNT_W-1:0]   occupancy;
    logic               err_ovf;
    logic               err_unexp;

    icache_resp_buffer #(
        .DATA_W  (DATA_W),
        .TXNID_W (TXNID_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_issue  (rd_issue),
        .rd_allow  (rd_allow),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .in_txnid  (in_txnid),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_txnid (out_txnid),
        .flush     (flush),
        .occupancy (occupancy),
        .err_ovf   (err_ovf),
        .err_unexp (err_unexp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered beats, outstanding reads, reads to discard.
    beat_t mq[$];
    int    m_infl;
    int    m_drop;
    bit    m_ovf;
    bit    m_unexp;

    beat_t               pend[$];
    logic [TXNID_W-1:0]  seen[$];

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic bit model_allow();
        return (mq.size() + m_infl) < DEPTH;
    endfunction

    task automatic model_reset();
        mq.delete();
        pend.delete();
        m_infl  = 0;
        m_drop  = 0;
        m_ovf   = 1'b0;
        m_unexp = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_vld", DATA_W'(out_vld), DATA_W'(mq.size() != 0));
        chk("occupancy", DATA_W'(occupancy), DATA_W'(mq.size()));
        chk("rd_allow", DATA_W'(rd_allow), DATA_W'(model_allow()));
        chk("err_ovf", DATA_W'(err_ovf), DATA_W'(m_ovf));
        chk("err_unexp", DATA_W'(err_unexp), DATA_W'(m_unexp));
        if (mq.size() != 0) begin
            chk("out_txnid", DATA_W'(out_txnid), DATA_W'(mq[0].id));
            chk("out_data", out_data, mq[0].d);
        end
    endtask

    task automatic model_step();
        bit    pop;
        int    ni;
        beat_t b;
        pop = (mq.size() != 0) && out_rdy;
        if (in_vld && m_infl == 0 && !rd_issue) m_unexp = 1'b1;
        ni = m_infl + int'(rd_issue) - int'(in_vld);
        if (ni < 0) ni = 0;
        if (flush) begin
            mq.delete();
            m_drop = ni;
        end else begin
            if (pop) void'(mq.pop_front());
            if (in_vld) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else if (mq.size() < DEPTH) begin
                    b.id = in_txnid;
                    b.d  = in_data;
                    mq.push_back(b);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_infl = ni;
    endtask

    task automatic set_in(input logic iss, input logic vld, input logic [TXNID_W-1:0] id,
                          input logic [DATA_W-1:0] d, input logic rdy, input logic fl);
        rd_issue = iss;
        in_vld   = vld;
        in_txnid = id;
        in_data  = d;
        out_rdy  = rdy;
        flush    = fl;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (out_vld && out_rdy) seen.push_back(out_txnid);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the upstream pipe: returns oldest pending read, optionally issues.
    task automatic pipe_cycle(input bit iss, input logic [TXNID_W-1:0] new_id,
                              input bit ret, input logic rdy, input logic fl);
        beat_t b;
        beat_t nb;
        bit    v;
        v = ret && (pend.size() != 0);
        b = '0;
        if (v) b = pend.pop_front();
        set_in(iss, v, b.id, b.d, rdy, fl);
        if (iss) begin
            nb.id = new_id;
            nb.d  = rand_data();
            pend.push_back(nb);
        end
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " out_vld"}, DATA_W'(out_vld), '0);
        chk({tag, " occupancy"}, DATA_W'(occupancy), '0);
        chk({tag, " rd_allow"}, DATA_W'(rd_allow), DATA_W'(1));
        chk({tag, " err_ovf"}, DATA_W'(err_ovf), '0);
        chk({tag, " err_unexp"}, DATA_W'(err_unexp), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] da5;
        int                issued;
        int                cyc;
        logic [TXNID_W-1:0] rid;

        da5 = {(DATA_W / 8){8'hA5}};
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read, one-cycle return, immediate consumption.
        set_in(1'b1, 1'b0, '0, '0, 1'b1, 1'b0); tick();
        set_in(1'b0, 1'b1, 4'd3, da5, 1'b1, 1'b0); tick();
        chk("t1 out_vld", DATA_W'(out_vld), DATA_W'(1));
        chk("t1 out_txnid", DATA_W'(out_txnid), DATA_W'(3));
        chk("t1 out_data", out_data, da5);
        set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); tick();
        chk("t1 occupancy", DATA_W'(occupancy), '0);

        // Credit limit with a stalled consumer.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0); tick();
        end
        chk("t2 rd_allow after 4 issues", DATA_W'(rd_allow), '0);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, TXNID_W'(i), rand_data(), 1'b0, 1'b0); tick();
        end
        chk("t2 occupancy full", DATA_W'(occupancy), DATA_W'(4));
        set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); tick();
        chk("t2 occupancy after pop", DATA_W'(occupancy), DATA_W'(3));
        chk("t2 rd_allow after pop", DATA_W'(rd_allow), DATA_W'(1));
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); tick();
        end

        // Wrap-around streaming with a toggling consumer.
        seen.delete();
        issued = 0;
        cyc    = 0;
        while ((issued < 10 || pend.size() != 0 || mq.size() != 0) && cyc < 200) begin
            pipe_cycle(issued < 10 && model_allow(), TXNID_W'(issued), 1'b1,
                       logic'(cyc % 2 == 0), 1'b0);
            if (rd_issue) issued++;
            cyc++;
        end
        chk("t3 delivered count", DATA_W'(seen.size()), DATA_W'(10));
        for (int i = 0; i < 10 && i < seen.size(); i++) begin
            chk("t3 delivery order", DATA_W'(seen[i]), DATA_W'(i));
        end
        chk("t3 err_ovf", DATA_W'(err_ovf), '0);
        chk("t3 err_unexp", DATA_W'(err_unexp), '0);

        // Flush with two buffered beats and one read outstanding.
        set_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b1, 4'd1, rand_data(), 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b1, 4'd2, rand_data(), 1'b0, 1'b0); tick();
        chk("t4 occupancy before flush", DATA_W'(occupancy), DATA_W'(2));
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b1); tick();
        chk("t4 out_vld after flush", DATA_W'(out_vld), '0);
        set_in(1'b0, 1'b1, 4'd5, rand_data(), 1'b0, 1'b0); tick();
        chk("t4 dropped beat occupancy", DATA_W'(occupancy), '0);
        chk("t4 rd_allow after drain", DATA_W'(rd_allow), DATA_W'(1));
        set_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b1, 4'd7, rand_data(), 1'b1, 1'b0); tick();
        chk("t4 post-flush out_vld", DATA_W'(out_vld), DATA_W'(1));
        chk("t4 post-flush out_txnid", DATA_W'(out_txnid), DATA_W'(7));
        set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); tick();

        // Forced overflow ignoring rd_allow.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0); tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, TXNID_W'(8 + i), rand_data(), 1'b0, 1'b0); tick();
        end
        chk("t5 occupancy", DATA_W'(occupancy), DATA_W'(4));
        chk("t5 err_ovf", DATA_W'(err_ovf), DATA_W'(1));
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); tick();
        end
        chk("t5 err_ovf sticky", DATA_W'(err_ovf), DATA_W'(1));

        // Unexpected return with nothing outstanding.
        set_in(1'b0, 1'b1, 4'd9, rand_data(), 1'b1, 1'b0); tick();
        chk("t6 err_unexp", DATA_W'(err_unexp), DATA_W'(1));
        set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); tick();
        set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); tick();
        chk("t6 err_unexp sticky", DATA_W'(err_unexp), DATA_W'(1));

        // Random traffic with occasional flushes and variable return latency.
        rid = '0;
        for (int i = 0; i < 400; i++) begin
            pipe_cycle(model_allow() && ($urandom_range(0, 1) == 1), rid,
                       $urandom_range(0, 3) != 0, logic'($urandom_range(0, 1)),
                       logic'($urandom_range(0, 19) == 0));
            if (rd_issue) rid = rid + 1'b1;
        end

        // Reset asserted mid-stream clears everything without waiting for a clock.
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            pipe_cycle(model_allow() && ($urandom_range(0, 1) == 1), rid, 1'b1,
                       logic'($urandom_range(0, 1)), 1'b0);
            if (rd_issue) rid = rid + 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
